// File: rtl/ktop_burst_pkg.sv
// ktop_burst_pkg: shared types and sizing helpers for the burst sequencer.
//   state_t        - sequencer FSM states
//   LP_*           - geometry for the default configuration
//   cnt_width()    - bits needed to hold 0..max_val inclusive
package ktop_burst_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam int C_BYTES_PER_BEAT_DEF  = 64;
  localparam int C_BURST_LEN_DEF       = 64;
  localparam int C_MAX_OUTSTANDING_DEF = 16;

  localparam int LP_BEAT_SHIFT  = $clog2(C_BYTES_PER_BEAT_DEF);
  localparam int LP_BURST_BYTES = C_BURST_LEN_DEF * C_BYTES_PER_BEAT_DEF;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int LP_OUT_W = cnt_width(C_MAX_OUTSTANDING_DEF);

endpackage

// File: rtl/ktop_burst_outstanding_cnt.sv
// ktop_burst_outstanding_cnt: saturating up/down count of in-flight bursts.
//   clk, rst      - clock, synchronous active-high reset
//   clken         - count enable
//   incr, decr    - burst issued / burst completed
//   cnt           - current count (0..MAX)
//   is_zero/full  - count == 0 / count == MAX
//   underflow     - decrement requested while empty (count held at 0)
module ktop_burst_outstanding_cnt
  import ktop_burst_pkg::*;
#(
  parameter int MAX = 16,
  parameter int W   = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clken,
  input  logic         incr,
  input  logic         decr,
  output logic [W-1:0] cnt,
  output logic         is_zero,
  output logic         is_full,
  output logic         underflow
);

  assign is_zero   = (cnt == '0);
  assign is_full   = (cnt == W'(MAX));
  // An issue and a completion in the same cycle cancel, so only a lone
  // decrement against an empty counter is an underflow.
  assign underflow = clken & decr & ~incr & is_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clken) begin
      if (incr && !decr && !is_full)      cnt <= cnt + 1'b1;
      else if (decr && !incr && !is_zero) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ktop_burst_sequencer.sv
// ktop_burst_sequencer: splits a kernel transfer into AXI-style bursts.
//   clk, rst                   - clock, synchronous active-high reset
//   ctrl_start                 - start pulse, taken only in IDLE
//   ctrl_addr_offset           - beat-aligned base byte address
//   ctrl_xfer_size_in_bytes    - transfer length in bytes
//   ctrl_done                  - one-cycle completion pulse
//   busy                       - start acceptance through ctrl_done
//   burst_valid/ready          - burst command handshake
//   burst_addr, burst_len      - burst start address, AXI len (beats-1)
//   burst_done                 - one pulse per completed burst
//   err                        - sticky: completion seen with none in flight
module ktop_burst_sequencer
  import ktop_burst_pkg::*;
#(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_XFER_SIZE_WIDTH = 32,
  parameter int C_BYTES_PER_BEAT  = C_BYTES_PER_BEAT_DEF,
  parameter int C_BURST_LEN       = C_BURST_LEN_DEF,
  parameter int C_MAX_OUTSTANDING = C_MAX_OUTSTANDING_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_done,
  output logic                         busy,
  output logic                         burst_valid,
  input  logic                         burst_ready,
  output logic [C_ADDR_WIDTH-1:0]      burst_addr,
  output logic [7:0]                   burst_len,
  input  logic                         burst_done,
  output logic                         err
);

  localparam int BEAT_SHIFT = $clog2(C_BYTES_PER_BEAT);
  // One spare bit so the round-up add never truncates.
  localparam int BW         = C_XFER_SIZE_WIDTH + 1;
  localparam int OW         = cnt_width(C_MAX_OUTSTANDING);

  state_t                  state, state_nxt;
  logic [C_ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]           remaining;
  logic [BW-1:0]           beats_in;
  logic [BW-1:0]           len_beats;
  logic [OW-1:0]           out_cnt;
  logic                    out_zero, out_full, out_underflow;
  logic                    start_acc, hs;

  assign beats_in  = ({1'b0, ctrl_xfer_size_in_bytes} + BW'(C_BYTES_PER_BEAT - 1)) >> BEAT_SHIFT;
  assign len_beats = (remaining > BW'(C_BURST_LEN)) ? BW'(C_BURST_LEN) : remaining;
  assign start_acc = (state == IDLE) & ctrl_start & ~rst;

  // Valid is a pure function of registered state; remaining/addr only move on
  // a handshake and the count can only fall while waiting, so the command
  // stays stable until accepted.
  assign burst_valid = (state == ISSUE) && (remaining != '0) && !out_full;
  assign hs          = burst_valid & burst_ready;
  assign burst_addr  = addr_q;
  assign burst_len   = (remaining == '0) ? 8'd0 : 8'(len_beats - 1'b1);
  assign ctrl_done   = (state == DONE);
  assign busy        = (state != IDLE) | start_acc;

  ktop_burst_outstanding_cnt #(.MAX(C_MAX_OUTSTANDING), .W(OW)) u_out_cnt (
    .clk       (clk),
    .rst       (rst),
    .clken     (1'b1),
    .incr      (hs),
    .decr      (burst_done),
    .cnt       (out_cnt),
    .is_zero   (out_zero),
    .is_full   (out_full),
    .underflow (out_underflow)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_start) state_nxt = (beats_in == '0) ? DONE : ISSUE;
      ISSUE:   if (hs && (remaining == len_beats)) state_nxt = DRAIN;
      DRAIN:   if (out_zero) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      remaining <= '0;
      err       <= 1'b0;
    end else begin
      if (start_acc) begin
        addr_q    <= ctrl_addr_offset;
        remaining <= beats_in;
      end else if (hs) begin
        addr_q    <= addr_q + (C_ADDR_WIDTH'(len_beats) << BEAT_SHIFT);
        remaining <= remaining - len_beats;
      end
      // A stray completion is the later event, so it wins over the clear.
      if (out_underflow)  err <= 1'b1;
      else if (start_acc) err <= 1'b0;
    end
  end

endmodule
